// File: rtl/proc_pkg.sv
// Shared processor types and widths for the instruction-fetch slice.
package proc_pkg;

  localparam int PC_W    = 7;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PREFETCH,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter: synchronous clear has priority over increment, wraps at 2^PC_W.
import proc_pkg::*;

module pc_counter (
  input  logic            clk,
  input  logic            Reset,
  input  logic            clr,
  input  logic            up,
  output logic [PC_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)     count <= '0;
    else if (clr)  count <= '0;
    else if (up)   count <= count + 1'b1;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, IR, and a one-entry prefetch buffer that is refilled
// with the word at the new PC after every IR load.
import proc_pkg::*;

module instr_fetch (
  input  logic               clk,
  input  logic               Reset,
  input  logic               PC_clr,
  input  logic               PC_up,
  input  logic               IR_Id,
  input  logic [INSTR_W-1:0] im_rdata,
  input  logic               im_ack,
  output logic               im_req,
  output logic [PC_W-1:0]    im_addr,
  output logic [INSTR_W-1:0] IR,
  output logic [PC_W-1:0]    PC,
  output logic               ir_valid,
  output logic               fetch_busy
);

  fetch_state_t       state_q, state_n;
  logic [PC_W-1:0]    req_addr_q, req_addr_n;
  logic               im_req_q, im_req_n;
  logic [INSTR_W-1:0] ir_q, ir_n;
  logic               ir_valid_q, ir_valid_n;
  logic               pf_valid_q, pf_valid_n;
  logic [PC_W-1:0]    pf_addr_q, pf_addr_n;
  logic [INSTR_W-1:0] pf_data_q, pf_data_n;
  logic               pend_inc_q, pend_inc_n;
  logic               pend_req_q, pend_req_n;
  logic               pend_up_q, pend_up_n;
  logic               pc_up_c;
  logic               svc_up;
  logic               hit;
  logic               ack_v;

  // Acks are only meaningful against our own outstanding request.
  assign ack_v = im_ack && im_req_q;
  assign hit   = pf_valid_q && (pf_addr_q == PC);

  pc_counter u_pc (
    .clk   (clk),
    .Reset (Reset),
    .clr   (PC_clr),
    .up    (pc_up_c),
    .count (PC)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n    = state_q;
    req_addr_n = req_addr_q;
    im_req_n   = im_req_q;
    ir_n       = ir_q;
    ir_valid_n = ir_valid_q;
    pf_valid_n = pf_valid_q;
    pf_addr_n  = pf_addr_q;
    pf_data_n  = pf_data_q;
    pend_inc_n = pend_inc_q;
    pend_req_n = pend_req_q;
    pend_up_n  = pend_up_q;
    pc_up_c    = 1'b0;
    svc_up     = pend_req_q ? pend_up_q : PC_up;

    if (PC_clr) begin
      pf_valid_n = 1'b0;
      pend_inc_n = 1'b0;
      pend_req_n = 1'b0;
      pend_up_n  = 1'b0;
      // An in-flight request must still be acked before the port is reusable.
      if (state_q != IDLE) begin
        if (ack_v) begin
          state_n  = IDLE;
          im_req_n = 1'b0;
        end else begin
          state_n  = DRAIN;
        end
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pend_req_q || IR_Id) begin
            pend_req_n = 1'b0;
            pend_up_n  = 1'b0;
            im_req_n   = 1'b1;
            if (hit) begin
              ir_n       = pf_data_q;
              ir_valid_n = 1'b1;
              pf_valid_n = 1'b0;
              pc_up_c    = svc_up;
              req_addr_n = svc_up ? PC + 1'b1 : PC;
              state_n    = PREFETCH;
            end else begin
              ir_valid_n = 1'b0;
              pend_inc_n = svc_up;
              req_addr_n = PC;
              state_n    = FETCH;
            end
          end else begin
            pc_up_c = PC_up;
          end
        end
        FETCH: begin
          pc_up_c = PC_up && !IR_Id;
          if (ack_v) begin
            ir_n       = im_rdata;
            ir_valid_n = 1'b1;
            pc_up_c    = pc_up_c || pend_inc_q;
            pend_inc_n = 1'b0;
            req_addr_n = (pc_up_c || pend_inc_q) ? PC + 1'b1 : PC;
            state_n    = PREFETCH;
          end
        end
        PREFETCH: begin
          if (IR_Id && !pend_req_q) begin
            pend_req_n = 1'b1;
            pend_up_n  = PC_up;
          end else begin
            pc_up_c = PC_up && !IR_Id;
          end
          if (ack_v) begin
            pf_data_n  = im_rdata;
            pf_addr_n  = req_addr_q;
            pf_valid_n = 1'b1;
            im_req_n   = 1'b0;
            state_n    = IDLE;
          end
        end
        DRAIN: begin
          pc_up_c = PC_up && !IR_Id;
          if (ack_v) begin
            im_req_n = 1'b0;
            state_n  = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: the prefetch buffer is a handful of flops, so it is reset like any other state.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      im_req_q   <= 1'b0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      pf_valid_q <= 1'b0;
      pf_addr_q  <= '0;
      pf_data_q  <= '0;
      pend_inc_q <= 1'b0;
      pend_req_q <= 1'b0;
      pend_up_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      req_addr_q <= req_addr_n;
      im_req_q   <= im_req_n;
      ir_q       <= ir_n;
      ir_valid_q <= ir_valid_n;
      pf_valid_q <= pf_valid_n;
      pf_addr_q  <= pf_addr_n;
      pf_data_q  <= pf_data_n;
      pend_inc_q <= pend_inc_n;
      pend_req_q <= pend_req_n;
      pend_up_q  <= pend_up_n;
    end
  end

  assign im_req     = im_req_q;
  assign im_addr    = req_addr_q;
  assign IR         = ir_q;
  assign ir_valid   = ir_valid_q;
  assign fetch_busy = (state_q == FETCH) || pend_req_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: hit/miss fetches, pending requests, clear/drain, wrap, reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        Reset;
  logic        PC_clr, PC_up, IR_Id;
  logic [15:0] im_rdata;
  logic        im_ack;
  logic        im_req;
  logic [6:0]  im_addr;
  logic [15:0] IR;
  logic [6:0]  PC;
  logic        ir_valid, fetch_busy;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch dut (
    .clk        (clk),
    .Reset      (Reset),
    .PC_clr     (PC_clr),
    .PC_up      (PC_up),
    .IR_Id      (IR_Id),
    .im_rdata   (im_rdata),
    .im_ack     (im_ack),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .IR         (IR),
    .PC         (PC),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ack_cycle(input logic [15:0] data);
    im_ack = 1'b1; im_rdata = data;
    tick();
    im_ack = 1'b0; im_rdata = 16'h0000;
  endtask

  initial begin
    Reset = 1'b1; PC_clr = 1'b0; PC_up = 1'b0; IR_Id = 1'b0;
    im_rdata = 16'h0000; im_ack = 1'b0;
    tick(); tick();
    check("rst_pc", PC, 7'd0);
    check("rst_ir", IR, 16'h0000);
    check("rst_irv", ir_valid, 1'b0);
    check("rst_req", im_req, 1'b0);
    check("rst_addr", im_addr, 7'd0);
    check("rst_busy", fetch_busy, 1'b0);
    Reset = 1'b0;
    tick();

    // Miss at PC 0, memory answers two cycles after the request.
    IR_Id = 1'b1; PC_up = 1'b1;
    tick();
    IR_Id = 1'b0; PC_up = 1'b0;
    check("miss_req", im_req, 1'b1);
    check("miss_addr", im_addr, 7'd0);
    check("miss_busy", fetch_busy, 1'b1);
    check("miss_irv", ir_valid, 1'b0);
    tick();
    ack_cycle(16'h3012);
    check("miss_ir", IR, 16'h3012);
    check("miss_pc", PC, 7'd1);
    check("miss_irv1", ir_valid, 1'b1);
    check("miss_busy0", fetch_busy, 1'b0);
    check("pf1_req", im_req, 1'b1);
    check("pf1_addr", im_addr, 7'd1);

    // Prefetch of addr 1 completes, then a buffer hit.
    tick();
    ack_cycle(16'h4021);
    check("pf1_done", im_req, 1'b0);
    IR_Id = 1'b1; PC_up = 1'b1;
    #1;
    check("hit_busy_pre", fetch_busy, 1'b0);
    tick();
    IR_Id = 1'b0; PC_up = 1'b0;
    check("hit_ir", IR, 16'h4021);
    check("hit_pc", PC, 7'd2);
    check("hit_busy", fetch_busy, 1'b0);
    check("pf2_addr", im_addr, 7'd2);
    check("pf2_req", im_req, 1'b1);

    // IR_Id while the prefetch of addr 2 is outstanding.
    IR_Id = 1'b1; PC_up = 1'b1;
    tick();
    IR_Id = 1'b0; PC_up = 1'b0;
    check("pend_busy", fetch_busy, 1'b1);
    check("pend_ir_hold", IR, 16'h4021);
    ack_cycle(16'h2051);
    check("pend_ir_wait", IR, 16'h4021);
    check("pend_req0", im_req, 1'b0);
    tick();
    check("pend_ir", IR, 16'h2051);
    check("pend_pc", PC, 7'd3);
    check("pend_busy0", fetch_busy, 1'b0);
    check("pf3_addr", im_addr, 7'd3);
    ack_cycle(16'h1111);

    // PC_clr during a miss fetch at addr 5.
    PC_up = 1'b1; tick(); tick(); PC_up = 1'b0;
    check("pc5", PC, 7'd5);
    IR_Id = 1'b1; tick(); IR_Id = 1'b0;
    check("f5_addr", im_addr, 7'd5);
    check("f5_busy", fetch_busy, 1'b1);
    PC_clr = 1'b1; tick(); PC_clr = 1'b0;
    check("clr_pc", PC, 7'd0);
    check("drain_req", im_req, 1'b1);
    check("drain_addr", im_addr, 7'd5);
    tick();
    check("drain_req2", im_req, 1'b1);
    ack_cycle(16'hBEEF);
    check("drain_ir", IR, 16'h2051);
    check("drain_done", im_req, 1'b0);
    IR_Id = 1'b1; tick(); IR_Id = 1'b0;
    check("f0_addr", im_addr, 7'd0);
    check("f0_busy", fetch_busy, 1'b1);
    ack_cycle(16'h5A5A);
    check("f0_ir", IR, 16'h5A5A);
    check("f0_pc", PC, 7'd0);
    ack_cycle(16'h0001);

    // PC wrap and clear priority.
    for (int i = 0; i < 127; i++) begin
      PC_up = 1'b1; tick();
    end
    PC_up = 1'b0;
    check("pc127", PC, 7'd127);
    PC_up = 1'b1; tick(); PC_up = 1'b0;
    check("pc_wrap", PC, 7'd0);
    PC_up = 1'b1; tick(); tick(); tick(); PC_up = 1'b0;
    check("pc3", PC, 7'd3);
    PC_clr = 1'b1; PC_up = 1'b1; IR_Id = 1'b1;
    tick();
    PC_clr = 1'b0; PC_up = 1'b0; IR_Id = 1'b0;
    check("prio_pc", PC, 7'd0);
    check("prio_req", im_req, 1'b0);
    check("prio_busy", fetch_busy, 1'b0);
    check("prio_ir", IR, 16'h5A5A);

    // Reset in the middle of a miss fetch at addr 1; late ack is ignored.
    PC_up = 1'b1; tick(); PC_up = 1'b0;
    IR_Id = 1'b1; tick(); IR_Id = 1'b0;
    check("f1_addr", im_addr, 7'd1);
    check("f1_irv", ir_valid, 1'b0);
    #2 Reset = 1'b1;
    #1;
    check("ar_pc", PC, 7'd0);
    check("ar_ir", IR, 16'h0000);
    check("ar_req", im_req, 1'b0);
    check("ar_addr", im_addr, 7'd0);
    check("ar_busy", fetch_busy, 1'b0);
    tick();
    Reset = 1'b0;
    tick();
    ack_cycle(16'hFFFF);
    check("late_ir", IR, 16'h0000);
    check("late_irv", ir_valid, 1'b0);
    check("late_req", im_req, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
